// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared constants for the RV32M multiply/divide unit
package rv32m_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/cond_neg.sv
// rtl/cond_neg.sv - conditional two's-complement negation
module cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/rv32m_muldiv.sv
// rtl/rv32m_muldiv.sv - fixed-latency iterative RV32M multiply/divide unit
// Magnitudes are computed at accept, the sign fix-up and special cases in FIX.
module rv32m_muldiv
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    logic        div0_q, div0_d, ovf_q, ovf_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic        a_signed, b_signed, a_sgn, b_sgn, is_div_in;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_top, div_diff;
    logic [63:0] div_next;
    logic [63:0] fix_in, fix_out;
    logic        fix_neg;
    logic [31:0] fix_res;
    logic        op_is_rem;

    assign a_signed  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                       (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign b_signed  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign a_sgn     = a_signed & a[31];
    assign b_sgn     = b_signed & b[31];
    assign is_div_in = funct3[2];

    cond_neg #(.W(32)) u_neg_a (.x(a), .neg(a_sgn), .y(mag_a));
    cond_neg #(.W(32)) u_neg_b (.x(b), .neg(b_sgn), .y(mag_b));

    // Multiply: acc = {partial, multiplier}; add in the top half, shift right.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc = {remainder, quotient}; shift left, trial subtract, restore on borrow.
    assign div_top  = acc_q[63:31];
    assign div_diff = div_top - {1'b0, opnd_q};
    assign div_next = div_diff[32] ? {div_top[31:0], acc_q[30:0], 1'b0}
                                   : {div_diff[31:0], acc_q[30:0], 1'b1};

    assign op_is_rem = op_q[2] & op_q[1];

    always_comb begin
        fix_in  = acc_q;
        fix_neg = a_neg_q ^ b_neg_q;
        if (op_q[2]) begin
            if (op_is_rem) begin
                fix_in  = {32'd0, acc_q[63:32]};
                fix_neg = a_neg_q;
            end else begin
                fix_in  = {32'd0, acc_q[31:0]};
            end
        end
    end

    cond_neg #(.W(64)) u_neg_fix (.x(fix_in), .neg(fix_neg), .y(fix_out));

    always_comb begin
        fix_res = fix_out[31:0];
        if (op_q == F3_MULH || op_q == F3_MULHSU || op_q == F3_MULHU) begin
            fix_res = fix_out[63:32];
        end
        if (op_q[2] && div0_q) begin
            fix_res = op_is_rem ? a_raw_q : DIV0_Q;
        end else if (op_q[2] && ovf_q) begin
            fix_res = op_is_rem ? 32'd0 : INT_MIN;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        a_raw_d  = a_raw_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    cnt_d   = 6'd0;
                    op_d    = funct3;
                    a_neg_d = a_sgn;
                    b_neg_d = b_sgn;
                    div0_d  = is_div_in && (b == 32'd0);
                    ovf_d   = is_div_in && !funct3[0] && (a == INT_MIN) && (b == 32'hFFFF_FFFF);
                    a_raw_d = a;
                    opnd_d  = is_div_in ? mag_b : mag_a;
                    acc_d   = {32'd0, is_div_in ? mag_a : mag_b};
                end
            end
            ST_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d  = ST_DONE;
                result_d = fix_res;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    assign busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    assign done_d = (state_d == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 3'd0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_raw_q  <= 32'd0;
            opnd_q   <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            a_raw_q  <= a_raw_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_rv32m_muldiv.sv
// tb/tb_rv32m_muldiv.sv - self-checking bench for rv32m_muldiv
module tb_rv32m_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_res = 32'd0;

    rv32m_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        logic [63:0]     p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        p  = 64'd0;
        case (f3)
            3'd0: p = ux * uy;
            3'd1: p = 64'(sx * sy) >> 32;
            3'd2: p = 64'(sx * longint'(uy)) >> 32;
            3'd3: p = (ux * uy) >> 32;
            3'd4: begin
                if (y == 32'd0) p = 64'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = 64'h8000_0000;
                else p = 64'(sx / sy);
            end
            3'd5: p = (y == 32'd0) ? 64'hFFFF_FFFF : (ux / uy);
            3'd6: begin
                if (y == 32'd0) p = {32'd0, x};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = 64'd0;
                else p = 64'(sx % sy);
            end
            default: p = (y == 32'd0) ? {32'd0, x} : (ux % uy);
        endcase
        return p[31:0];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #1;
        funct3 = f3;
        a      = x;
        b      = y;
        start  = 1'b1;
    endtask

    // Waits for done, counting cycles after the current one; checks latency, result, stability.
    task automatic wait_done(input string name, input logic [31:0] exp_res, input int exp_cyc,
                             input bit chk_busy, input bit keep);
        int          got;
        bit          stable;
        logic [31:0] prev;
        got    = -1;
        stable = 1'b1;
        prev   = last_res;
        for (int c = 1; c <= exp_cyc + 3; c++) begin
            @(posedge clk);
            #1;
            if (chk_busy) check({name, " busy"}, {31'd0, busy}, (c < exp_cyc) ? 32'd1 : 32'd0);
            if (done) begin
                got = c;
                break;
            end
            if (result !== prev) stable = 1'b0;
        end
        check({name, " latency"}, 32'(got), 32'(exp_cyc));
        check({name, " result"}, result, exp_res);
        check({name, " stable"}, {31'd0, stable}, 32'd1);
        last_res = exp_res;
        if (!keep) start = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        tbl[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        tbl[9]  = '{3'd7, 32'd5,          32'd0,         32'd5};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        tbl[12] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
        tbl[13] = '{3'd5, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].f3, tbl[i].a, tbl[i].b);
            wait_done($sformatf("vec%0d", i), tbl[i].exp, 34, 1'b1, 1'b0);
        end

        // Flush in cycle 10 with start still high: restart accepted in cycle 11, done in cycle 45.
        issue(3'd5, 32'd1000, 32'd3);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 10) flush = 1'b1;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush result", result, last_res);
        wait_done("flush restart", 32'd333, 34, 1'b0, 1'b0);

        // Back-to-back with start held: second done in cycle 69.
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("b2b op1", 32'hFFFF_FFFE, 34, 1'b0, 1'b1);
        funct3 = 3'd5;
        a      = 32'd100;
        b      = 32'd7;
        wait_done("b2b op2", 32'd14, 35, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  rf;
            logic [31:0] ra, rb;
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            issue(rf, ra, rb);
            wait_done($sformatf("rand%0d f3=%0d a=%h b=%h", i, rf, ra, rb),
                      ref_model(rf, ra, rb), 34, 1'b0, 1'b0);
        end

        // Reset in cycle 20 of an operation clears outputs immediately.
        issue(3'd0, 32'd3, 32'd5);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("rst mid busy", {31'd0, busy}, 32'd0);
        check("rst mid done", {31'd0, done}, 32'd0);
        check("rst mid result", result, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        last_res = 32'd0;
        issue(3'd0, 32'd3, 32'd5);
        wait_done("after rst", 32'd15, 34, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv32m_muldiv.md
# rv32m_muldiv

Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU. It takes operands and funct3 from the ID/EX pipeline register and produces a 32-bit result. That result is written into the EX/MEM pipeline register, whose load enable the hazard unit holds low while this block is busy. Fixed latency for every operation, including divide-by-zero and overflow, keeps stall control trivial.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: request. Sampled only in IDLE. Held high by the pipeline until `done`.
- `funct3`, input, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`, input, 32: rs1 value (multiplicand/dividend).
- `b`, input, 32: rs2 value (multiplier/divisor).
- `flush`, input, 1: abort from branch/exception; overrides everything except `rst`.
- `busy`, output, 1: operation in progress (CALC or FIX). Used by the stall logic.
- `done`, output, 1: one-cycle pulse. `result` is valid in this cycle.
- `result`, output, 32: registered result. Holds its value until the next DONE.

## Operation
- **States:**
  - IDLE → CALC on `start` (and not `flush`).
  - CALC → FIX after 32 iterations.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- **Accept (in IDLE with `start`):**
  - Latch `funct3`, sign flags and operand magnitudes.
  - Signed: MULH (`a`, `b`), MULHSU (`a` only), DIV/REM (both). Unsigned: all others.
  - Clear the 6-bit iteration counter.
- **Multiply:**
  - Radix-2 shift-add over a 64-bit accumulator of magnitudes.
  - Product negated in FIX when the operand signs differ (MULHSU: when `a` < 0).
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- **Divide:**
  - Restoring division on magnitudes using a 33-bit subtract.
  - Quotient negated if signs differ (DIV). Remainder takes the dividend's sign (REM).
- **Special cases:** flagged at accept, applied in FIX, latency unchanged.
  - `b` = 0: quotient 0xFFFFFFFF; remainder = `a`.
  - DIV/REM with `a` = 0x80000000 and `b` = 0xFFFFFFFF: quotient 0x80000000; remainder 0.
- **`result`:** loaded on the FIX→DONE edge only.
- **`flush`:** any state → IDLE on the next edge; `done` is not asserted and `result` is unchanged. If `flush` and `start` are both high in IDLE, the request is not accepted.
- **`start` outside IDLE:** ignored, so a still-high `start` during DONE does not restart the unit.
- **Reset:** state IDLE, counter 0, `busy` 0, `done` 0, `result` 0. Takes effect immediately, including mid-operation.

## Timing
- Cycle 0: `start` high in IDLE, sampled at the end-of-cycle edge.
- Cycles 1–32: CALC. Cycle 33: FIX. Cycle 34: DONE, with `done` = 1 and `result` valid.
- `busy` = 1 in cycles 1–33, 0 in cycle 34. `done` and `busy` are never high together.
- Stall request to the hazard unit is `start & ~done`. The EX/MEM register loads in cycle 34.
- Back-to-back: the next request is sampled in cycle 35 (IDLE), giving 35 cycles per op.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `rv32m_pkg`:
  - funct3 localparams `F3_MUL`…`F3_REMU`.
  - State encoding IDLE/CALC/FIX/DONE (2 bits).
  - Constants `DIV0_Q` = 32'hFFFFFFFF and `INT_MIN` = 32'h80000000.
- One sub-module, `cond_neg`: parameterised width, output = `neg ? -x : x`.
  - Instanced for operand magnitudes (32-bit) and for the FIX correction (64-bit).
- The FSM, counter and shift datapath stay in `rv32m_muldiv`.

## Test plan
- MUL `a`=7, `b`=0xFFFFFFFD: `result` 0xFFFFFFEB with `done` in cycle 34, `busy` high in cycles 1–33 only.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero and overflow:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - All complete in cycle 34.
- Flush and reset mid-operation:
  - `flush` in cycle 10 → `busy` 0 in cycle 11, no `done`, `result` unchanged. A new `start` in cycle 11 completes in cycle 45.
  - `rst` asserted in cycle 20 → all outputs 0 immediately.
- Back-to-back with `start` held high: one `done` per op. The second op's `done` arrives in cycle 69, and the first op's `result` stays stable in between.
